// File: rtl/pipelined_averager.sv
// Pipelined unsigned averager: input register, registered adder tree, per-sample shift, output
// register. Define AVG_SATURATE_EN to saturate out-of-range results and report them on ovf.
module pipelined_averager #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned LOG2N     = 3,
  parameter int unsigned SUMWIDTH  = DATAWIDTH + LOG2N
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [(2**LOG2N)*DATAWIDTH-1:0] din,
  input  logic [7:0]                      sh_amt,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATAWIDTH-1:0]            avg,
  output logic                            ovf,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int unsigned NUM_IN = 2 ** LOG2N;
  localparam int unsigned NODES  = NUM_IN - 1;
`ifdef AVG_SATURATE_EN
  localparam int unsigned SHR_W  = SUMWIDTH;
`else
  localparam int unsigned SHR_W  = DATAWIDTH;
`endif
  localparam logic [7:0]  SH_MAX = 8'(SUMWIDTH);

  logic                            stall;
  logic [NUM_IN*DATAWIDTH-1:0]     din_q;
  logic [SUMWIDTH-1:0]             node_q [NODES];
  logic [SUMWIDTH-1:0]             node_d [NODES];
  logic [SUMWIDTH-1:0]             tree   [2*NUM_IN-1];
  logic [LOG2N:0]                  vld_q;
  logic [LOG2N:0][7:0]             sh_q;
  logic [SHR_W-1:0]                shr_d, shr_q;
  logic                            shr_vld_q;
  logic [DATAWIDTH-1:0]            avg_d, avg_q;
  logic                            out_valid_q;
`ifdef AVG_SATURATE_EN
  logic                            ovf_d, ovf_q;
`endif

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Heap-ordered tree: node i sums children 2i+1 and 2i+2; leaves sit after the NODES sums.
  // A node at depth d is loaded LOG2N-d cycles after its leaves, so each depth is one stage.
  for (genvar i = 0; i < NODES; i++) begin : g_node
    assign tree[i]   = node_q[i];
    assign node_d[i] = tree[2*i+1] + tree[2*i+2];
  end

  for (genvar k = 0; k < NUM_IN; k++) begin : g_leaf
    assign tree[NODES+k] = SUMWIDTH'(din_q[k*DATAWIDTH +: DATAWIDTH]);
  end

  // Root is tree[0]; its shift amount is the one that travelled with it.
  assign shr_d = (sh_q[LOG2N] >= SH_MAX) ? '0 : SHR_W'(tree[0] >> sh_q[LOG2N]);

  always_comb begin
`ifdef AVG_SATURATE_EN
    ovf_d = |shr_q[SUMWIDTH-1:DATAWIDTH];
    avg_d = ovf_d ? '1 : shr_q[DATAWIDTH-1:0];
`else
    avg_d = shr_q;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_q       <= '0;
      shr_vld_q   <= 1'b0;
      out_valid_q <= 1'b0;
      avg_q       <= '0;
`ifdef AVG_SATURATE_EN
      ovf_q       <= 1'b0;
`endif
    end else if (!stall) begin
      din_q       <= din;
      sh_q        <= {sh_q[LOG2N-1:0], sh_amt};
      vld_q       <= {vld_q[LOG2N-1:0], in_valid};
      node_q      <= node_d;
      shr_q       <= shr_d;
      shr_vld_q   <= vld_q[LOG2N];
      avg_q       <= avg_d;
      out_valid_q <= shr_vld_q;
`ifdef AVG_SATURATE_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign avg       = avg_q;
  assign out_valid = out_valid_q;
`ifdef AVG_SATURATE_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_averager.sv
// Scoreboard bench for pipelined_averager: default 8x16 instance plus a 2x8 instance.
module tb_pipelined_averager;

  localparam int DW  = 16;
  localparam int L2  = 3;
  localparam int NI  = 8;
  localparam int SW  = DW + L2;
  localparam int LAT = L2 + 2;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic             Rst;
  logic [NI*DW-1:0] din;
  logic [7:0]       sh_amt;
  logic             in_valid, in_ready;
  logic [DW-1:0]    avg;
  logic             ovf, out_valid, out_ready;

  logic [15:0]      din2;
  logic [7:0]       sh2;
  logic             iv2, ir2, ovf2, ov2, or2;
  logic [7:0]       avg2;

  pipelined_averager #(.DATAWIDTH(DW), .LOG2N(L2)) dut (
    .Clk(Clk), .Rst(Rst), .din(din), .sh_amt(sh_amt), .in_valid(in_valid),
    .in_ready(in_ready), .avg(avg), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  pipelined_averager #(.DATAWIDTH(8), .LOG2N(1)) dut2 (
    .Clk(Clk), .Rst(Rst), .din(din2), .sh_amt(sh2), .in_valid(iv2),
    .in_ready(ir2), .avg(avg2), .ovf(ovf2), .out_valid(ov2), .out_ready(or2)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic          o;
    int            t;
    bit            lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;
  bit   rand_rdy = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [NI*DW-1:0] d, input logic [7:0] s);
    exp_t r;
    longint unsigned sum = 0;
    longint unsigned v;
    for (int k = 0; k < NI; k++) sum += longint'(d[k*DW +: DW]);
    v = (int'(s) >= SW) ? 0 : (sum >> s);
`ifdef AVG_SATURATE_EN
    if (v > 65535) begin
      r.a = '1;
      r.o = 1'b1;
    end else begin
      r.a = DW'(v);
      r.o = 1'b0;
    end
`else
    r.a = DW'(v % 65536);
    r.o = 1'b0;
`endif
    r.t   = 0;
    r.lat = 1'b0;
    return r;
  endfunction

  function automatic logic [NI*DW-1:0] fill(input logic [DW-1:0] v);
    logic [NI*DW-1:0] d;
    for (int k = 0; k < NI; k++) d[k*DW +: DW] = v;
    return d;
  endfunction

  function automatic logic [NI*DW-1:0] seq18();
    logic [NI*DW-1:0] d;
    for (int k = 0; k < NI; k++) d[k*DW +: DW] = DW'(k + 1);
    return d;
  endfunction

  function automatic logic [NI*DW-1:0] rand_din();
    logic [NI*DW-1:0] d;
    int mode = $urandom_range(0, 3);
    for (int k = 0; k < NI; k++)
      d[k*DW +: DW] = (mode == 0) ? DW'($urandom_range(16'hF000, 16'hFFFF)) : DW'($urandom);
    return d;
  endfunction

  task automatic chk(input string n, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  // Monitor: handshake rule every cycle, input transfers feed the model, output transfers pop.
  always @(negedge Clk) begin
    if (Rst) begin
      sb.delete();
    end else begin
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: avg %h ovf %b with nothing pending", avg, ovf);
        end else begin
          e = sb.pop_front();
          if (avg !== e.a || ovf !== e.o) begin
            errors++;
            $display("FAIL result: got avg %h ovf %b expected avg %h ovf %b", avg, ovf, e.a, e.o);
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.t != LAT) begin
              errors++;
              $display("FAIL latency: got %0d expected %0d", cyc - e.t, LAT);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        e     = model(din, sh_amt);
        e.t   = cyc + 1;
        e.lat = chk_lat;
        sb.push_back(e);
      end
    end
  end

  initial forever begin
    @(posedge Clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic send(input logic [NI*DW-1:0] d, input logic [7:0] s, input bit lat);
    int n = 0;
    din      = d;
    sh_amt   = s;
    in_valid = 1'b1;
    chk_lat  = lat;
    @(negedge Clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge Clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge Clk);
      n++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic check_reset_state();
    @(negedge Clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_avg", avg, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    int n;
    Rst = 1'b1; in_valid = 1'b0; din = '0; sh_amt = '0; out_ready = 1'b1;
    iv2 = 1'b0; din2 = '0; sh2 = '0; or2 = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    check_reset_state();
    @(posedge Clk);
    #1;

    // Directed samples, back to back, latency checked on each.
    send(fill(16'h0010), 8'd3, 1'b1);
    send(fill(16'hFFFF), 8'd0, 1'b1);
    send(fill(16'hFFFF), 8'd3, 1'b1);
    send(seq18(), 8'd40, 1'b1);
    send(seq18(), 8'd1, 1'b1);
    drain();

    // Ten-sample stream with out_ready low for cycles 3..6.
    fork
      for (int i = 0; i < 10; i++) send(rand_din(), 8'($urandom_range(0, 6)), 1'b0);
      begin
        repeat (3) @(posedge Clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge Clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-flight discards in-flight samples.
    send(fill(16'h0001), 8'd0, 1'b0);
    send(fill(16'h0002), 8'd0, 1'b0);
    din = fill(16'h0003); in_valid = 1'b1; Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0; in_valid = 1'b0;
    check_reset_state();
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk("no_out_after_rst", out_valid, 0);
    end
    @(posedge Clk);
    #1;
    send(fill(16'h0100), 8'd2, 1'b1);
    drain();

    // Random traffic with random backpressure and gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(rand_din(), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 8)), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clk);
        #1;
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Two-channel 8-bit instance: 0x80 + 0x80 >> 1, three-cycle latency.
    @(posedge Clk);
    #1;
    din2 = {8'h80, 8'h80}; sh2 = 8'd1; iv2 = 1'b1;
    @(negedge Clk);
    chk("small_in_ready", ir2, 1);
    @(posedge Clk);
    #1 iv2 = 1'b0;
    n = 0;
    do begin
      @(posedge Clk);
      #1;
      n++;
    end while (!ov2 && n < 20);
    chk("small_latency", n, 3);
    chk("small_avg", avg2, 8'h80);
    chk("small_ovf", ovf2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
